resource_arbiter: RTL and testbench

Responder end of the pipeline arbiter_req/arbiter_grant interface. Accepts requests from NUM_REQ pipeline instances and grants the single shared resource to one of them, using round-robin order and a bounded burst length. It forwards the owner's resource_input word to the resource. It tracks each issued word through the resource's fixed latency and steers the result back to the originating requester with a one-hot valid.

---
 rtl/resource_arbiter_pkg.sv | 21 ++
 rtl/resource_arbiter_if.sv | 26 ++
 rtl/resource_arbiter_rr_pick.sv | 35 +++
 rtl/resource_arbiter.sv | 147 ++++++++++++++
 tb/tb_resource_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/resource_arbiter_pkg.sv
// Shared constants and types for the round-robin resource arbiter.
// ID_W is derived from the default NUM_REQ; overrides of NUM_REQ must keep the same id width.
package resource_arb_pkg;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int RES_LAT   = 2;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/resource_arbiter_if.sv
// Request/grant, resource issue and result-return bundle between the pipelines,
// the shared resource and the arbiter (the arbiter is the slave end).
interface resource_arbiter_if #(
    parameter int NUM_REQ = resource_arb_pkg::NUM_REQ,
    parameter int DATA_W  = resource_arb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      flush;
    logic [NUM_REQ-1:0]        grant;
    logic                      res_in_valid;
    logic [DATA_W-1:0]         res_in_data;
    logic [DATA_W-1:0]         res_out_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;

    modport slave (
        input  req, req_data, flush, res_out_data,
        output grant, res_in_valid, res_in_data, resp_valid, resp_data
    );

    modport master (
        output req, req_data, flush, res_out_data,
        input  grant, res_in_valid, res_in_data, resp_valid, resp_data
    );
endinterface

// File: rtl/resource_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible request at or above rr_ptr,
// wrapping, with excluded requesters masked out.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_valid
);
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_win;
    logic [2*NUM_REQ-1:0] dbl_right;
    logic [2*NUM_REQ-1:0] dbl_left;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        cand      = req & ~exclude;
        dbl_right = {cand, cand} >> rr_ptr;
        rot       = dbl_right[NUM_REQ-1:0];
        rot_win   = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rot[k] && !any_valid) begin
                rot_win[k] = 1'b1;
                any_valid  = 1'b1;
            end
        end
        dbl_left = {rot_win, rot_win} << rr_ptr;
        winner   = dbl_left[2*NUM_REQ-1:NUM_REQ];
    end
endmodule

// File: rtl/resource_arbiter.sv
// Round-robin owner of one shared fixed-latency resource with bounded bursts;
// a tag pipe follows each issued word so its result returns to the requester.
module resource_arbiter #(
    parameter int NUM_REQ   = resource_arb_pkg::NUM_REQ,
    parameter int DATA_W    = resource_arb_pkg::DATA_W,
    parameter int RES_LAT   = resource_arb_pkg::RES_LAT,
    parameter int MAX_BURST = resource_arb_pkg::MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    resource_arbiter_if.slave arb
);
    import resource_arb_pkg::*;

    localparam int                 BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

    arb_state_e         state, state_nx;
    logic [ID_W-1:0]    owner, owner_nx, rr_ptr, rr_ptr_nx, pick_idx;
    logic [BURST_W-1:0] burst_cnt, burst_nx;
    logic [NUM_REQ-1:0] excl, pick_oh, grant_q, resp_valid_q;
    logic               pick_any, transfer, do_release;
    logic [DATA_W-1:0]  req_words [NUM_REQ];
    logic [DATA_W-1:0]  resp_data_q;
    tag_t               tag_pipe [RES_LAT];
    tag_t               tag_last;

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        return (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign req_words[g] = arb.req_data[g*DATA_W +: DATA_W];
    end

    // The current owner is never a hand-off candidate.
    assign excl = (state == OWN) ? (ONE << owner) : '0;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(ID_W)) u_pick (
        .req      (arb.req),
        .rr_ptr   (rr_ptr),
        .exclude  (excl),
        .winner   (pick_oh),
        .any_valid(pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = ID_W'(i);
        end
    end

    assign transfer         = |(grant_q & arb.req);
    assign arb.grant        = grant_q;
    assign arb.res_in_valid = transfer;
    assign arb.res_in_data  = transfer ? req_words[owner] : '0;
    assign arb.resp_valid   = resp_valid_q;
    assign arb.resp_data    = resp_data_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nx   = state;
        owner_nx   = owner;
        rr_ptr_nx  = rr_ptr;
        burst_nx   = burst_cnt;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx  = OWN;
                    owner_nx  = pick_idx;
                    burst_nx  = '0;
                    rr_ptr_nx = ptr_after(pick_idx);
                end
            end
            OWN: begin
                if (!arb.req[owner]) begin
                    do_release = 1'b1;
                end else if (burst_cnt == BURST_LAST && pick_any) begin
                    do_release = 1'b1;
                end else if (burst_cnt != BURST_LAST) begin
                    burst_nx = burst_cnt + 1'b1;
                end
                if (do_release) begin
                    burst_nx = '0;
                    if (pick_any) begin
                        owner_nx  = pick_idx;
                        rr_ptr_nx = ptr_after(pick_idx);
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Flush wins over everything and leaves the round-robin pointer alone.
        if (arb.flush) begin
            state_nx  = IDLE;
            owner_nx  = owner;
            rr_ptr_nx = rr_ptr;
            burst_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_q   <= '0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values, independent of statement order.
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_nx;
            grant_q   <= (state_nx == OWN) ? (ONE << owner_nx) : '0;
        end
    end

    assign tag_last = tag_pipe[RES_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this array is reset on purpose; stale valid bits would return phantom results after reset.
            for (int k = 0; k < RES_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= arb.flush ? '0 : '{valid: transfer, id: owner};
            for (int k = 1; k < RES_LAT; k++) tag_pipe[k] <= arb.flush ? '0 : tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else if (arb.flush) begin
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= tag_last.valid ? (ONE << tag_last.id) : '0;
            if (tag_last.valid) resp_data_q <= arb.res_out_data;
        end
    end
endmodule

// File: tb/tb_resource_arbiter.sv
// Randomized and directed stimulus for resource_arbiter, checked every cycle
// against a transaction-level model (owner/pointer integers plus an in-flight queue).
module tb_resource_arbiter;
    import resource_arb_pkg::*;

    localparam int N  = NUM_REQ;
    localparam int W  = DATA_W;
    localparam int L  = RES_LAT;
    localparam int MB = MAX_BURST;

    typedef struct {
        int due;
        int id;
    } flight_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    resource_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    resource_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LAT(L), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .reset(reset),
        .arb  (bus)
    );

    // Reference model state
    bit             m_own;
    int             m_owner, m_rr, m_burst, cyc;
    logic [N-1:0]   m_resp_valid;
    logic [W-1:0]   m_resp_data;
    flight_t        inflight[$];

    // Last observed outputs, for directed checks against fixed expectations
    logic [N-1:0]   obs_grant, obs_resp_valid;
    logic           obs_in_valid;
    logic [W-1:0]   obs_in_data;

    logic [N-1:0]   r, eg;
    logic [N*W-1:0] d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (rq[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic void model_reset();
        m_own        = 1'b0;
        m_owner      = 0;
        m_rr         = 0;
        m_burst      = 0;
        m_resp_valid = '0;
        m_resp_data  = '0;
        inflight.delete();
    endfunction

    // One clock cycle: drive, compare, advance the model, cross the edge.
    task automatic tick(input logic [N-1:0] rq, input logic f, input logic [N*W-1:0] dv);
        logic         xfer;
        logic [N-1:0] exp_grant;
        logic [W-1:0] exp_data;
        int           w;
        bit           rel;
        bus.req          = rq;
        bus.flush        = f;
        bus.req_data     = dv;
        bus.res_out_data = W'($urandom);
        #1;
        xfer      = m_own && rq[m_owner];
        exp_grant = m_own ? (N'(1) << m_owner) : '0;
        exp_data  = xfer ? dv[m_owner*W +: W] : '0;
        check("grant", bus.grant, exp_grant);
        check("res_in_valid", bus.res_in_valid, xfer);
        check("res_in_data", bus.res_in_data, exp_data);
        check("resp_valid", bus.resp_valid, m_resp_valid);
        check("resp_data", bus.resp_data, m_resp_data);
        obs_grant      = bus.grant;
        obs_resp_valid = bus.resp_valid;
        obs_in_valid   = bus.res_in_valid;
        obs_in_data    = bus.res_in_data;

        m_resp_valid = '0;
        if (!f && inflight.size() > 0 && inflight[0].due == cyc) begin
            m_resp_valid = N'(1) << inflight[0].id;
            m_resp_data  = bus.res_out_data;
        end
        if (inflight.size() > 0 && inflight[0].due == cyc) void'(inflight.pop_front());
        if (f) inflight.delete();
        else if (xfer) inflight.push_back('{due: cyc + L, id: m_owner});

        if (f) begin
            m_own   = 1'b0;
            m_burst = 0;
        end else if (!m_own) begin
            w = pick(rq, m_rr, -1);
            if (w >= 0) begin
                m_own   = 1'b1;
                m_owner = w;
                m_burst = 0;
                m_rr    = (w + 1) % N;
            end
        end else begin
            w   = pick(rq, m_rr, m_owner);
            rel = !rq[m_owner] || (m_burst == MB - 1 && w >= 0);
            if (!rel) begin
                if (m_burst < MB - 1) m_burst++;
            end else if (w >= 0) begin
                m_owner = w;
                m_burst = 0;
                m_rr    = (w + 1) % N;
            end else begin
                m_own   = 1'b0;
                m_burst = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic apply_reset();
        bus.req   = '0;
        bus.flush = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_grant", bus.grant, '0);
        check("rst_resp_valid", bus.resp_valid, '0);
        check("rst_resp_data", bus.resp_data, '0);
        check("rst_in_valid", bus.res_in_valid, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.req          = '0;
        bus.req_data     = '0;
        bus.flush        = 1'b0;
        bus.res_out_data = '0;
        cyc              = 0;
        model_reset();
        #2;

        // Single requester: 1-cycle grant latency, RES_LAT+1 result latency
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            d          = rand_data();
            d[W-1:0]   = W'(32'hA5);
            tick(N'(1), 1'b0, d);
            if (k == 0) check("t1_grant_c0", obs_grant, '0);
            if (k == 1) begin
                check("t1_grant_c1", obs_grant, N'(1));
                check("t1_in_data_c1", obs_in_data, 32'hA5);
            end
            if (k == L + 2) check("t1_resp_valid", obs_resp_valid, N'(1));
        end

        // All requesting: MB-cycle turns in round-robin order, no bubbles
        apply_reset();
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(i);
        for (int k = 0; k < 1 + N * MB + MB; k++) begin
            tick('1, 1'b0, d);
            eg = (k == 0) ? '0 : N'(1) << (((k - 1) / MB) % N);
            check("t2_rr_grant", obs_grant, eg);
            if (k > 0) check("t2_one_xfer", obs_in_valid, 1'b1);
        end

        // Owner 2 drops early; hand-off to 0, then rr_ptr=1 favours 1 over 3
        apply_reset();
        tick(4'b0100, 1'b0, rand_data());
        tick(4'b0101, 1'b0, rand_data());
        tick(4'b0001, 1'b0, rand_data());
        tick(4'b0011, 1'b0, rand_data());
        check("t3_grant_to_0", obs_grant, 4'b0001);
        tick(4'b1010, 1'b0, rand_data());
        tick(4'b0010, 1'b0, rand_data());
        check("t3_grant_to_1", obs_grant, 4'b0010);

        // Lone requester keeps ownership past the burst limit
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            tick(4'b0010, 1'b0, rand_data());
            if (k > 0) check("t4_hold_grant", obs_grant, 4'b0010);
        end

        // Flush alongside the third issued word kills all three results
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            r = (k < 4) ? 4'b0001 : ((k >= 6) ? 4'b0010 : 4'b0000);
            tick(r, (k == 3), rand_data());
            if (k == 4) check("t5_grant_after_flush", obs_grant, '0);
            if (k >= 4) check("t5_no_resp", obs_resp_valid, '0);
            if (k == 7) check("t5_regrant", obs_grant, 4'b0010);
        end

        // Reset mid-burst with two words in flight
        apply_reset();
        for (int k = 0; k < 3; k++) tick('1, 1'b0, rand_data());
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            tick('0, 1'b0, rand_data());
            check("t6_grant_idle", obs_grant, '0);
            check("t6_resp_dropped", obs_resp_valid, '0);
        end
        for (int k = 0; k < 3; k++) begin
            tick(4'b0100, 1'b0, rand_data());
            if (k == 1) check("t6_regrant", obs_grant, 4'b0100);
        end

        // Randomized: sticky requests, occasional flush
        apply_reset();
        r = '0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(4) == 0) r[i] = ~r[i];
            end
            tick(r, ($urandom_range(24) == 0), rand_data());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
